// File: rtl/me_fullsearch_if.sv
// Port bundle of the full-search motion estimator: control, both ROM read ports and the result.
// The engine takes the master side; the environment (ROMs, controller) takes the slave side.
interface me_fullsearch_if #(
    parameter int BLOCK = 16,
    parameter int RANGE = 8,
    parameter int PIXW  = 8
);
    localparam int SW   = BLOCK + 2*RANGE - 1;
    localparam int AW   = $clog2(BLOCK*BLOCK);
    localparam int ASW  = $clog2(SW*SW);
    localparam int SADW = PIXW + AW;
    localparam int MVW  = $clog2(RANGE) + 1;

    logic                   start;
    logic                   early_term_en;
    logic [AW-1:0]          AddressR;
    logic [PIXW-1:0]        R;
    logic [ASW-1:0]         AddressS;
    logic [PIXW-1:0]        S;
    logic [SADW-1:0]        BestDist;
    logic signed [MVW-1:0]  motionX;
    logic signed [MVW-1:0]  motionY;
    logic                   busy;
    logic                   completed;

    modport master (
        input  start, early_term_en, R, S,
        output AddressR, AddressS, BestDist, motionX, motionY, busy, completed
    );
    modport slave (
        output start, early_term_en, R, S,
        input  AddressR, AddressS, BestDist, motionX, motionY, busy, completed
    );
endinterface

// File: rtl/me_fullsearch_engine.sv
// Full-search block-matching motion estimator: one reference and one window pixel per cycle,
// SAD per candidate, keeps the first minimum in raster scan order, optional partial-SAD abort.
module me_fullsearch_engine #(
    parameter int BLOCK = 16,
    parameter int RANGE = 8,
    parameter int PIXW  = 8
) (
    input logic             clock,
    input logic             reset,
    me_fullsearch_if.master bus
);
    localparam int SW   = BLOCK + 2*RANGE - 1;
    localparam int NPIX = BLOCK*BLOCK;
    localparam int AW   = $clog2(NPIX);
    localparam int ASW  = $clog2(SW*SW);
    localparam int SADW = PIXW + AW;
    localparam int MVW  = $clog2(RANGE) + 1;
    localparam logic [MVW-1:0] CLAST = MVW'(2*RANGE - 1);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;
    state_t state, state_nxt;

    // Candidate held as unsigned window offset (dx+RANGE, dy+RANGE) so reset gives AddressS=0.
    logic [AW-1:0]   p;
    logic [MVW-1:0]  cx, cy;
    logic [MVW-1:0]  mvx, mvy;
    logic [SADW-1:0] acc, acc_sum, best;
    logic [PIXW:0]   ad;
    logic [1:0]      vld_pipe;
    logic            busy, completed, et_en;
    logic            abort, last_pix, last_cand, better;

    assign bus.AddressR  = p;
    assign bus.AddressS  = ASW'((int'(p) / BLOCK + int'(cy)) * SW + int'(p) % BLOCK + int'(cx));
    assign bus.BestDist  = best;
    assign bus.motionX   = mvx;
    assign bus.motionY   = mvy;
    assign bus.busy      = busy;
    assign bus.completed = completed;

    // vld_pipe[1] marks that R/S carry data for a read issued last cycle and not discarded.
    always_comb begin
        ad        = (bus.R >= bus.S) ? {1'b0, bus.R} - {1'b0, bus.S}
                                     : {1'b0, bus.S} - {1'b0, bus.R};
        acc_sum   = vld_pipe[1] ? acc + SADW'(ad) : acc;
        abort     = et_en && (acc_sum >= best);
        last_pix  = (p == AW'(NPIX - 1));
        last_cand = (cx == CLAST) && (cy == CLAST);
        better    = (acc_sum < best);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = RUN;
            RUN:        if (abort || last_pix) state_nxt = CMP;
            CMP:        state_nxt = last_cand ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p         <= '0;
            cx        <= '0;
            cy        <= '0;
            mvx       <= '0;
            mvy       <= '0;
            acc       <= '0;
            best      <= '0;
            busy      <= 1'b0;
            completed <= 1'b0;
            et_en     <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0] & ~abort, state_nxt == RUN};
            case (state)
                IDLE, DONE: if (bus.start) begin
                    completed <= 1'b0;
                    busy      <= 1'b1;
                    best      <= '1;
                    et_en     <= bus.early_term_en;
                    p         <= '0;
                    cx        <= '0;
                    cy        <= '0;
                    acc       <= '0;
                end
                RUN: begin
                    acc <= acc_sum;
                    if (!(abort || last_pix)) p <= p + 1'b1;
                end
                CMP: begin
                    if (better) begin
                        best <= acc_sum;
                        mvx  <= cx - MVW'(RANGE);
                        mvy  <= cy - MVW'(RANGE);
                    end
                    acc <= '0;
                    p   <= '0;
                    cx  <= (cx == CLAST) ? '0 : cx + 1'b1;
                    if (cx == CLAST) cy <= (cy == CLAST) ? '0 : cy + 1'b1;
                    if (last_cand) begin
                        busy      <= 1'b0;
                        completed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
